// File: rtl/uart_rx_param_if.sv
// Receive-side bus between the UART receiver and the register logic.
// The receiver owns the FIFO head view and status flags.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd;
   logic                 clr_err;
   logic [DATA_BITS-1:0] data;
   logic                 frame_err;
   logic                 parity_err;
   logic                 rdy;
   logic                 overrun;
   logic                 busy;

   modport master (
      input  rd, clr_err,
      output data, frame_err, parity_err, rdy, overrun, busy
   );

   modport slave (
      output rd, clr_err,
      input  data, frame_err, parity_err, rdy, overrun, busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample vote, framing/parity
// checks and a show-ahead receive FIFO with sticky overrun.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk_50m,
   input  logic rst,
   input  logic clk_en,
   input  logic rx,
   uart_rx_param_if.master rxb
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_BITS + 2;

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

   logic [1:0]           sync_q;
   logic [2:0]           vote_q;
   logic                 rx_s;
   logic                 vote;
   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 push;
   logic [EW-1:0]        entry;

   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wp_q, rp_q, last_idx;
   logic [AW:0]          fcnt_q;
   logic                 full, pop, wr, ovf;
   logic                 ovr_q;
   logic [EW-1:0]        head;

   assign rx_s = sync_q[1];
   assign vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                 (vote_q[1] & vote_q[2]);

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
         vote_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[0], rx};
         if (clk_en) vote_q <= {vote_q[1:0], rx_s};
      end
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      push    = 1'b0;
      entry   = {ferr_q | ~vote, perr_q, sh_q};
      if (clk_en) begin
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
                  // a start that has gone high again by mid-bit is noise
                  if (vote) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     cnt_d   = '0;
                     bit_d   = '0;
                     perr_d  = 1'b0;
                     ferr_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA, PAR, STOP: begin
               if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                  cnt_d = '0;
                  if (state_q == DATA) begin
                     sh_d  = {vote, sh_q[DATA_BITS-1:1]};
                     bit_d = bit_q + 1'b1;
                     if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                     end
                  end else if (state_q == PAR) begin
                     perr_d  = ((^sh_q) ^ vote) != (PARITY == 1);
                     bit_d   = '0;
                     state_d = STOP;
                  end else begin
                     ferr_d = ferr_q | ~vote;
                     bit_d  = bit_q + 1'b1;
                     if (bit_q == 4'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = IDLE;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign full = fcnt_q == (AW + 1)'(FIFO_DEPTH);
   assign pop  = rxb.rd & rxb.rdy;
   assign wr   = push & (~full | pop);
   assign ovf  = push & full & ~pop;

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
         fcnt_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         if (wr) begin
            mem_q[wp_q] <= entry;
            wp_q        <= wp_q + 1'b1;
         end
         if (pop) rp_q <= rp_q + 1'b1;
         case ({wr, pop})
            2'b10:   fcnt_q <= fcnt_q + 1'b1;
            2'b01:   fcnt_q <= fcnt_q - 1'b1;
            default: fcnt_q <= fcnt_q;
         endcase
         if (ovf)              ovr_q <= 1'b1;
         else if (rxb.clr_err) ovr_q <= 1'b0;
      end
   end

   // when empty the slot behind the read pointer still holds the last head
   assign last_idx = rp_q - AW'(1);
   assign head     = (fcnt_q != '0) ? mem_q[rp_q] : mem_q[last_idx];

   assign rxb.data       = head[DATA_BITS-1:0];
   assign rxb.parity_err = head[DATA_BITS];
   assign rxb.frame_err  = head[DATA_BITS+1];
   assign rxb.rdy        = fcnt_q != '0;
   assign rxb.overrun    = ovr_q;
   assign rxb.busy       = state_q != IDLE;
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 Bluetooth-module receiver.
- Generalises data width, oversampling ratio, parity and stop-bit count.
- Adds a 2-flop input synchroniser, 3-sample majority voting, false-start rejection, framing/parity error reporting, and a small show-ahead receive FIFO with overrun detection.
- Sits between the Bluetooth module RX pin and the game-control register logic; clk_en comes from the shared baud-tick generator at OVERSAMPLE x baud.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, clk_en ticks per bit; must be even, at least 8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, at least 2.

Ports:
- clk_50m  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  oversample tick, one clk_50m cycle wide.
- rx  in  1  serial line; asynchronous, idles high.
- rd  in  1  pop the FIFO head; honoured only when rdy=1.
- clr_err  in  1  clears the sticky overrun flag.
- data  out  DATA_BITS  FIFO head data, LSB = first received bit.
- frame_err  out  1  FIFO head entry had a stop bit sampled as 0.
- parity_err  out  1  FIFO head entry failed parity; always 0 when PARITY=0.
- rdy  out  1  FIFO not empty.
- overrun  out  1  sticky: a completed frame was dropped because the FIFO was full.
- busy  out  1  receiver state is not IDLE.

Behaviour:
- Reset, asynchronous, active-high:
  - state IDLE; sample counter and bit counter 0.
  - Synchroniser flops and vote shift register all 1.
  - FIFO empty; data, frame_err, parity_err, rdy, overrun, busy all 0.
  - Asserting rst mid-frame discards the partial frame; FIFO contents are lost.
- Input path:
  - rx passes through 2 flops (rx_s), giving 2 cycles of latency.
  - On each clk_en, rx_s shifts into a 3-bit vote register.
  - vote = majority of those 3 bits.
- All state and counter updates happen only on clk_en cycles. FIFO pop, clr_err and outputs act on every cycle.
- IDLE:
  - On rx_s=0: go to START with the counter cleared to 0.
- START:
  - The counter increments each tick.
  - At count OVERSAMPLE/2-1 (mid start bit), evaluate vote.
  - vote=1 is a false start: return to IDLE, no push.
  - vote=0: clear the counter, clear the bit counter, go to DATA.
- DATA:
  - The counter runs 0..OVERSAMPLE-1 and wraps.
  - At count OVERSAMPLE-1, shift vote into the shift register (LSB first) and increment the bit counter.
  - After DATA_BITS samples: go to PARITY if PARITY!=0, else go to STOP.
- PARITY:
  - Sample one bit the same way.
  - parity_err_int = 1 if XOR(data bits, parity bit) != (PARITY==1 ? 1 : 0).
- STOP:
  - Sample STOP_BITS bits the same way.
  - frame_err_int = 1 if any stop sample is 0.
  - On the final stop sample: push {frame_err_int, parity_err_int, data} and go to IDLE on that same tick. The frame completes at mid-stop, which tolerates baud drift.
  - No wait for the end of the stop bit: a start edge seen on the next tick is accepted.
- Break (line held low): a frame of all zeros with frame_err=1 is pushed, then the receiver re-arms in IDLE and treats continued low as a new start.
- FIFO (show-ahead):
  - data, frame_err and parity_err reflect the head whenever rdy=1. They hold their last value when empty.
  - Pop on rd & rdy; rd while empty is ignored.
  - Push and pop in the same cycle: both happen, count unchanged. This also applies when full, so the push is accepted.
  - Push while full without a pop: the frame is dropped and overrun is set to 1. overrun stays set until clr_err=1.
  - If clr_err and a new overrun occur in the same cycle, overrun=1 (set wins).
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (state != IDLE), registered with the state.
- Latency: rdy rises 1 clk_50m cycle after the clk_en at the final stop sample.

Test Plan:
- Defaults, clk_en every 4 cycles, send 0xA5 as 8N1 -> one push; data=0xA5, frame_err=0, parity_err=0, rdy=1; pulse rd -> rdy=0.
- Low glitch of 3 ticks on rx during IDLE -> false start, busy returns to 0, rdy stays 0.
- PARITY=2, send 0x3C with parity bit 1 -> parity_err=1. Send 0x3C with parity bit 0 -> parity_err=0, entries in order.
- Send 0x55 with stop bit 0 -> frame_err=1, data=0x55. A following good frame 0x12 is received cleanly with frame_err=0.
- FIFO_DEPTH=4, send 5 frames 0x01..0x05 with no rd -> FIFO holds 0x01..0x04, overrun=1. Read 4 times -> 0x01..0x04 in order. Pulse clr_err -> overrun=0.
- Assert rst mid-frame (after 3 data bits), release it, send 0x7E -> only 0x7E received. Single mid-bit glitch (1 tick) in a data bit -> majority vote yields the correct byte.
